// File: rtl/dac_playback_pkg.sv
// Shared types and default sizes for the DAC waveform playback engine.
package dac_playback_pkg;

    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_ADDR_BITS  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2
    } dac_state_e;

endpackage

// File: rtl/dac_playback_if.sv
// AXI4-Stream beat channel from the playback engine towards the DAC.
interface dac_playback_if import dac_playback_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    // A beat transfers on a rising edge where tvalid and tready are both high.
    // Once tvalid rises it stays high, with tdata frozen, until that transfer.
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/dac_wave_ram.sv
// Simple dual-port waveform store with one-cycle registered read (block RAM).
module dac_wave_ram import dac_playback_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dac_playback.sv
// Plays a RAM-resident waveform onto an AXI4-Stream DAC link, optionally
// looping and optionally aligned to a SYSREF rising edge.
module dac_playback import dac_playback_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
    input  logic                  aclk,
    input  logic                  arst,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_BITS-1:0]  len,
    input  logic                  loop_en,
    input  logic                  sync_en,
    input  logic                  sysref,
    input  logic                  start,
    input  logic                  stop,
    dac_playback_if.master        m_axis,
    output logic                  busy,
    output logic                  done,
    output dac_state_e            fsm_state
);

    dac_state_e state, state_next;

    logic [ADDR_BITS-1:0]  len_q, rd_addr, cur_len;
    logic                  loop_q, cur_loop, sysref_q, sysref_rise;
    logic                  fetch_done, rd_pending, stopping, stopping_next;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] skid [2];
    logic                  rd_ptr, wr_ptr;
    logic [1:0]            count;
    logic [2:0]            credit;
    logic                  fetch, go_idle, latch, trim, kill, push, pop;

    dac_wave_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_BITS(ADDR_BITS)) u_ram (
        .clk   (aclk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    assign sysref_rise = sysref && !sysref_q;
    assign cur_len     = (state == ST_IDLE) ? len : len_q;
    assign cur_loop    = (state == ST_IDLE) ? loop_en : loop_q;
    assign pop         = (count != 2'd0) && m_axis.tready;
    // Reads in flight plus buffered beats never exceed the two skid slots.
    assign credit      = 3'(count) - 3'(pop) + 3'(rd_pending);
    assign push        = rd_pending && !kill;

    always_ff @(posedge aclk) begin
        if (arst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        fetch         = 1'b0;
        go_idle       = 1'b0;
        latch         = 1'b0;
        trim          = 1'b0;
        kill          = 1'b0;
        stopping_next = stopping;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    latch = 1'b1;
                    if (sync_en) begin
                        state_next = ST_ARMED;
                    end else begin
                        state_next = ST_PLAY;
                        fetch      = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    go_idle    = 1'b1;
                end else if (sysref_rise) begin
                    state_next = ST_PLAY;
                    fetch      = 1'b1;
                end
            end
            ST_PLAY: begin
                kill = stop || stopping;
                if (kill) begin
                    // Only the beat already on the bus may still go out.
                    if (count == 2'd0 || pop) begin
                        state_next = ST_IDLE;
                        go_idle    = 1'b1;
                    end else begin
                        stopping_next = 1'b1;
                        trim          = 1'b1;
                    end
                end else begin
                    fetch = !fetch_done && (credit < 3'd2);
                    if (fetch_done && !rd_pending && count == 2'd1 && pop) begin
                        state_next = ST_IDLE;
                        go_idle    = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            len_q      <= '0;
            loop_q     <= 1'b0;
            sysref_q   <= 1'b0;
            done       <= 1'b0;
            rd_addr    <= '0;
            fetch_done <= 1'b0;
            rd_pending <= 1'b0;
            stopping   <= 1'b0;
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
        end else begin
            sysref_q <= sysref;
            done     <= go_idle;
            if (latch) begin
                len_q  <= len;
                loop_q <= loop_en;
            end
            if (go_idle) begin
                rd_addr    <= '0;
                fetch_done <= 1'b0;
                rd_pending <= 1'b0;
                stopping   <= 1'b0;
                count      <= 2'd0;
                rd_ptr     <= 1'b0;
                wr_ptr     <= 1'b0;
            end else begin
                rd_pending <= fetch;
                stopping   <= stopping_next;
                if (fetch) begin
                    if (rd_addr == cur_len) begin
                        rd_addr <= '0;
                        if (!cur_loop) begin
                            fetch_done <= 1'b1;
                        end
                    end else begin
                        rd_addr <= rd_addr + ADDR_BITS'(1);
                    end
                end
                if (trim) begin
                    count <= 2'd1;
                end else begin
                    if (push) begin
                        wr_ptr <= ~wr_ptr;
                    end
                    if (pop) begin
                        rd_ptr <= ~rd_ptr;
                    end
                    count <= count + 2'(push) - 2'(pop);
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            skid[wr_ptr] <= ram_q;
        end
    end

    assign m_axis.tvalid = (count != 2'd0);
    assign m_axis.tdata  = (count != 2'd0) ? skid[rd_ptr] : '0;
    assign busy          = (state != ST_IDLE);
    assign fsm_state     = state;

endmodule
